fetch_stage: RTL and testbench

Instruction fetch stage of the five-stage pipeline. It owns the program counter and drives the synchronous instruction memory. It delivers one instruction and its PC+1 per cycle to the fetch/decode pipeline latch. It absorbs decode-side stalls with a one-entry skid buffer and accepts taken-branch/jump redirects from execute, squashing wrong-path fetches.

---
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem addressing, one-entry skid buffer, redirect squash
// Optional FETCH_PERF_EN adds fetch/bubble performance counters.
module fetch_stage #(
    parameter int          ADDR_W = 12,
    parameter logic [31:0] NOP    = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_imem,
    input  logic [31:0]       q_imem,
    input  logic              in_stall,
    input  logic              in_redirect,
    input  logic [31:0]       in_target,
    output logic [31:0]       out_IR,
    output logic [31:0]       out_PC_next,
    output logic              out_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       out_fetch_count,
    output logic [31:0]       out_bubble_count
`endif
);

    // STREAM: a read is in flight (data on q_imem now); HELD: one instruction parked in the skid
    typedef enum logic [1:0] {
        S_EMPTY  = 2'b00,
        S_STREAM = 2'b01,
        S_HELD   = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] skid_ir_q, skid_ir_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic [31:0] sel_ir;
    logic [31:0] sel_pc_next;

    assign address_imem = pc_q[ADDR_W-1:0];

    always_comb begin
        sel_ir      = NOP;
        sel_pc_next = 32'd0;
        case (state_q)
            S_HELD: begin
                sel_ir      = skid_ir_q;
                sel_pc_next = skid_pc_q + 32'd1;
            end
            S_STREAM: begin
                sel_ir      = q_imem;
                sel_pc_next = pend_pc_q + 32'd1;
            end
            default: begin
                sel_ir      = NOP;
                sel_pc_next = 32'd0;
            end
        endcase
        out_valid   = (state_q != S_EMPTY) && !in_redirect;
        out_IR      = out_valid ? sel_ir : NOP;
        out_PC_next = sel_pc_next;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        skid_ir_d = skid_ir_q;
        skid_pc_d = skid_pc_q;
        if (in_redirect) begin
            pc_d    = in_target;
            state_d = S_EMPTY;
        end else if (in_stall && out_valid) begin
            if (state_q == S_STREAM) begin
                skid_ir_d = q_imem;
                skid_pc_d = pend_pc_q;
                state_d   = S_HELD;
            end
        end else begin
            // Includes EMPTY under stall: prefetching is harmless because the latch is held anyway
            pend_pc_d = pc_q;
            pc_d      = pc_q + 32'd1;
            state_d   = S_STREAM;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_EMPTY;
            pc_q      <= 32'd0;
            pend_pc_q <= 32'd0;
            skid_ir_q <= NOP;
            skid_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            skid_ir_q <= skid_ir_d;
            skid_pc_q <= skid_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    always_comb begin
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;
        if (out_valid && !in_stall) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (!out_valid) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q  <= 32'd0;
            bubble_count_q <= 32'd0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign out_fetch_count  = fetch_count_q;
    assign out_bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a transaction-level reference model
module tb_fetch_stage;

    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] address_imem;
    logic [31:0]   q_imem;
    logic          in_stall;
    logic          in_redirect;
    logic [31:0]   in_target;
    logic [31:0]   out_IR;
    logic [31:0]   out_PC_next;
    logic          out_valid;
`ifdef FETCH_PERF_EN
    logic [31:0]   out_fetch_count;
    logic [31:0]   out_bubble_count;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:(1<<AW)-1];

    fetch_stage #(.ADDR_W(AW), .NOP(32'h0000_0000)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_imem (address_imem),
        .q_imem       (q_imem),
        .in_stall     (in_stall),
        .in_redirect  (in_redirect),
        .in_target    (in_target),
        .out_IR       (out_IR),
        .out_PC_next  (out_PC_next),
        .out_valid    (out_valid)
`ifdef FETCH_PERF_EN
        ,
        .out_fetch_count  (out_fetch_count),
        .out_bubble_count (out_bubble_count)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) q_imem <= mem[address_imem];

    // Model: m_head is the PC of the instruction being presented; m_delay counts cycles until it shows
    logic [31:0] m_head  = 32'd0;
    int          m_delay = 1;
    logic [31:0] m_fetch = 32'd0;
    logic [31:0] m_bubble = 32'd0;

    always @(posedge clock) begin
        if (reset) begin
            m_head   <= 32'd0;
            m_delay  <= 1;
            m_fetch  <= 32'd0;
            m_bubble <= 32'd0;
        end else begin
            if (in_redirect) begin
                m_head  <= in_target;
                m_delay <= 1;
            end else if (m_delay > 0) begin
                m_delay <= m_delay - 1;
            end else if (!in_stall) begin
                m_head <= m_head + 32'd1;
            end
            if ((m_delay == 0) && !in_redirect && !in_stall) m_fetch <= m_fetch + 32'd1;
            if (!((m_delay == 0) && !in_redirect)) m_bubble <= m_bubble + 32'd1;
        end
    end

    task automatic cyc(input logic rst, input logic st, input logic rd, input logic [31:0] tg);
        reset       = rst;
        in_stall    = st;
        in_redirect = rd;
        in_target   = tg;
        @(negedge clock);
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input bit rnd);
        for (int i = 0; i < (1 << AW); i++) mem[i] = rnd ? $urandom : (32'h1000_0000 + 32'(i));
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        nxt();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        n_vec++;
        if ({out_valid, out_IR, out_PC_next} !== {1'b0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%0b ir=%h pcn=%h exp 0/0/0", out_valid, out_IR, out_PC_next);
        end
        n_vec++;
        if (address_imem !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_addr got %h exp 000", address_imem);
        end
        nxt();
    endtask

    task automatic test_free_run();
        logic [64:0] e;
        do_reset(1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'd0);
            n_vec++;
            if (address_imem !== 12'(k)) begin
                n_fail++;
                $display("FAIL free_run_addr k=%0d got %h exp %h", k, address_imem, 12'(k));
            end
            if (k >= 1) begin
                e = {1'b1, 32'h1000_0000 + 32'(k - 1), 32'(k)};
                n_vec++;
                if ({out_valid, out_IR, out_PC_next} !== e) begin
                    n_fail++;
                    $display("FAIL free_run k=%0d got %h exp %h", k, {out_valid, out_IR, out_PC_next}, e);
                end
            end
            nxt();
        end
    endtask

    task automatic test_stall_hold();
        logic [64:0] e;
        do_reset(1'b0);
        for (int k = 0; k < 11; k++) begin
            cyc(1'b0, (k >= 3 && k <= 6), 1'b0, 32'd0);
            if (k >= 3 && k <= 7) begin
                e = {1'b1, 32'h1000_0002, 32'd3};
                n_vec++;
                if (address_imem !== 12'd3) begin
                    n_fail++;
                    $display("FAIL stall_addr k=%0d got %h exp 003", k, address_imem);
                end
            end else if (k >= 1) begin
                e = {1'b1, 32'h1000_0000 + 32'(k - 2 + (k < 3 ? 1 : 0)), 32'(k - 1 + (k < 3 ? 1 : 0))};
                if (k >= 8) e = {1'b1, 32'h1000_0000 + 32'(k - 5), 32'(k - 4)};
            end else begin
                e = {1'b0, 32'd0, 32'd0};
            end
            n_vec++;
            if ({out_valid, out_IR, out_PC_next} !== e) begin
                n_fail++;
                $display("FAIL stall k=%0d got %h exp %h", k, {out_valid, out_IR, out_PC_next}, e);
            end
            nxt();
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, (k == 5), 32'h40);
            if (k == 5 || k == 6) begin
                n_vec++;
                if (out_valid !== 1'b0 || out_IR !== 32'd0) begin
                    n_fail++;
                    $display("FAIL redirect_squash k=%0d got v=%0b ir=%h exp 0/0", k, out_valid, out_IR);
                end
            end
            if (k == 6) begin
                n_vec++;
                if (address_imem !== 12'h040) begin
                    n_fail++;
                    $display("FAIL redirect_addr got %h exp 040", address_imem);
                end
            end
            if (k >= 7) begin
                n_vec++;
                if ({out_valid, out_IR, out_PC_next} !== {1'b1, 32'h1000_0040 + 32'(k - 7), 32'h41 + 32'(k - 7)}) begin
                    n_fail++;
                    $display("FAIL redirect_target k=%0d got v=%0b ir=%h pcn=%h", k, out_valid, out_IR, out_PC_next);
                end
            end
            nxt();
        end
    endtask

    task automatic test_redirect_in_stall();
        logic [64:0] e;
        do_reset(1'b0);
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, (k >= 3 && k <= 9), (k == 5), 32'h80);
            if (k == 3 || k == 4)      e = {1'b1, 32'h1000_0002, 32'd3};
            else if (k == 5 || k == 6) e = {1'b0, 32'd0, 32'hx};
            else if (k >= 7 && k <= 10) e = {1'b1, 32'h1000_0080, 32'h81};
            else if (k == 11)          e = {1'b1, 32'h1000_0081, 32'h82};
            else                       e = {1'b1, 32'h1000_0000 + 32'(k - 1), 32'(k)};
            if (k >= 1) begin
                n_vec++;
                if ({out_valid, out_IR} !== e[64:32] || (e[64] && out_PC_next !== e[31:0])) begin
                    n_fail++;
                    $display("FAIL redirect_stall k=%0d got %h exp %h", k, {out_valid, out_IR, out_PC_next}, e);
                end
            end
            nxt();
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, (k == 1 || k == 5), (k == 1) ? 32'hFFF : 32'hFFFF_FFFF);
            if (k == 3) begin
                n_vec++;
                if ({out_valid, out_IR, out_PC_next, address_imem} !== {1'b1, 32'h1000_0FFF, 32'h1000, 12'h000}) begin
                    n_fail++;
                    $display("FAIL wrap_addr got v=%0b ir=%h pcn=%h a=%h exp 1/10000fff/1000/000", out_valid, out_IR, out_PC_next, address_imem);
                end
            end
            if (k == 4) begin
                n_vec++;
                if ({out_valid, out_IR, out_PC_next} !== {1'b1, 32'h1000_0000, 32'h1001}) begin
                    n_fail++;
                    $display("FAIL wrap_next got v=%0b ir=%h pcn=%h exp 1/10000000/1001", out_valid, out_IR, out_PC_next);
                end
            end
            if (k == 7 || k == 8) begin
                n_vec++;
                if ({out_valid, out_IR, out_PC_next} !== {1'b1, (k == 7) ? 32'h1000_0FFF : 32'h1000_0000, 32'(k - 7)}) begin
                    n_fail++;
                    $display("FAIL wrap32 k=%0d got v=%0b ir=%h pcn=%h", k, out_valid, out_IR, out_PC_next);
                end
            end
            nxt();
        end
    endtask

    task automatic test_reset_held();
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc((k == 4), (k >= 2), 1'b0, 32'd0);
            if (k == 3) begin
                n_vec++;
                if ({out_valid, out_IR} !== {1'b1, 32'h1000_0001}) begin
                    n_fail++;
                    $display("FAIL held_before_reset got v=%0b ir=%h exp 1/10000001", out_valid, out_IR);
                end
            end
            if (k == 5) begin
                n_vec++;
                if ({out_valid, out_IR, out_PC_next, address_imem} !== {1'b0, 32'd0, 32'd0, 12'd0}) begin
                    n_fail++;
                    $display("FAIL held_reset got v=%0b ir=%h pcn=%h a=%h exp 0/0/0/0", out_valid, out_IR, out_PC_next, address_imem);
                end
`ifdef FETCH_PERF_EN
                n_vec++;
                if (out_fetch_count !== 32'd0 || out_bubble_count !== 32'd0) begin
                    n_fail++;
                    $display("FAIL held_reset_counters got f=%0d b=%0d exp 0/0", out_fetch_count, out_bubble_count);
                end
`endif
            end
            nxt();
        end
    endtask

    task automatic test_random();
        logic        r, st, rd;
        logic [31:0] tg;
        logic        ev;
        do_reset(1'b1);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       tg = 32'($urandom_range(0, 4095));
                1:       tg = 32'hFF0 + 32'($urandom_range(0, 15));
                default: tg = $urandom;
            endcase
            cyc(r, st, rd, tg);
            if (!r) begin
                ev = (m_delay == 0) && !rd;
                n_vec++;
                if (out_valid !== ev) begin
                    n_fail++;
                    $display("FAIL rnd_valid i=%0d got %0b exp %0b", i, out_valid, ev);
                end
                n_vec++;
                if (out_IR !== (ev ? mem[m_head[AW-1:0]] : 32'd0)) begin
                    n_fail++;
                    $display("FAIL rnd_ir i=%0d got %h exp %h", i, out_IR, ev ? mem[m_head[AW-1:0]] : 32'd0);
                end
                n_vec++;
                if (out_PC_next !== ((m_delay == 0) ? m_head + 32'd1 : 32'd0)) begin
                    n_fail++;
                    $display("FAIL rnd_pcn i=%0d got %h exp %h", i, out_PC_next, (m_delay == 0) ? m_head + 32'd1 : 32'd0);
                end
                n_vec++;
                if (address_imem !== ((m_delay != 0) ? m_head[AW-1:0] : m_head[AW-1:0] + 12'd1)) begin
                    n_fail++;
                    $display("FAIL rnd_addr i=%0d got %h head=%h delay=%0d", i, address_imem, m_head, m_delay);
                end
`ifdef FETCH_PERF_EN
                n_vec++;
                if (out_fetch_count !== m_fetch || out_bubble_count !== m_bubble) begin
                    n_fail++;
                    $display("FAIL rnd_counters i=%0d got f=%0d b=%0d exp f=%0d b=%0d", i, out_fetch_count, out_bubble_count, m_fetch, m_bubble);
                end
`endif
            end
            nxt();
        end
    endtask

    initial begin
        reset       = 1'b1;
        in_stall    = 1'b0;
        in_redirect = 1'b0;
        in_target   = 32'd0;
        @(posedge clock);
        #1;
        test_reset();
        test_free_run();
        test_stall_hold();
        test_redirect();
        test_redirect_in_stall();
        test_wrap();
        test_reset_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
